zhegalkin_anf_sweeper: RTL and testbench

//  Sequencer for a combinational Zhegalkin (ANF) function evaluator with N inputs.
//  On start, drives every input vector 0..2^N-1 into the evaluator and captures the truth table.
//  It then runs an in-place Reed-Muller (Moebius) transform to recover the ANF coefficient vector.
//  It reports truth table, ANF and weight through a start/busy/done handshake.

---
 rtl/zhegalkin_pkg.sv | 23 ++
 rtl/zhegalkin_moebius_stage.sv | 27 ++
 rtl/zhegalkin_anf_sweeper.sv | 98 +++++++++
 tb/tb_zhegalkin_anf_sweeper.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/zhegalkin_pkg.sv
// Shared types and helpers for the Zhegalkin ANF sweeper.
package zhegalkin_pkg;

    // Sequencer states, 2-bit encoded.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        XFORM = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Default evaluator input width.
    localparam int N_DEFAULT = 4;

    // Width of the butterfly stage index (covers N up to 6).
    localparam int STAGE_W = 3;

    // Truth-table width for an n-input function.
    function automatic int tt_w(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/zhegalkin_moebius_stage.sv
// One stage of the Reed-Muller (Moebius) butterfly, fully parallel.
// Every bit whose index has bit s set absorbs its partner at distance 2^s;
// all other bits pass through unchanged.
module zhegalkin_moebius_stage
    import zhegalkin_pkg::*;
#(
    parameter int N    = N_DEFAULT,
    parameter int TT_W = tt_w(N)
) (
    input  logic [TT_W-1:0]    vec,
    input  logic [STAGE_W-1:0] s,
    output logic [TT_W-1:0]    vec_out
);

    logic [TT_W-1:0] upper_mask;
    logic [TT_W-1:0] partner;

    // Mark the bits whose index has bit s set.
    for (genvar i = 0; i < TT_W; i++) begin : g_mask
        assign upper_mask[i] = ((i >> s) & 1) != 0;
    end

    // Bit i of partner holds vec[i - 2^s], which equals vec[i ^ 2^s] for masked bits.
    assign partner = vec << (TT_W'(1) << s);
    assign vec_out = vec ^ (partner & upper_mask);

endmodule

// File: rtl/zhegalkin_anf_sweeper.sv
// Sweeps all 2^N input vectors through a combinational evaluator, captures
// the truth table, then runs N butterfly stages in place to get the ANF.
// Handshake: start (sampled in IDLE only), busy during SWEEP/XFORM,
// one-cycle done pulse; res_valid stays high until the next accepted start.
module zhegalkin_anf_sweeper
    import zhegalkin_pkg::*;
#(
    parameter int N    = N_DEFAULT,
    parameter int TT_W = tt_w(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N-1:0]    eval_x,
    input  logic            eval_z,
    output logic            busy,
    output logic            done,
    output logic            res_valid,
    output logic [TT_W-1:0] truth_tab,
    output logic [TT_W-1:0] anf,
    output logic [N:0]      weight,
    output logic [1:0]      state_dbg
);

    localparam logic [N:0]         LAST_IDX   = (N+1)'(TT_W - 1);
    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(N - 1);

    state_t               state;
    logic [N:0]           idx;
    logic [STAGE_W-1:0]   stage;
    logic [TT_W-1:0]      anf_next;

    zhegalkin_moebius_stage #(.N(N), .TT_W(TT_W)) u_stage (
        .vec     (anf),
        .s       (stage),
        .vec_out (anf_next)
    );

    // Outputs decoded from registered state, so eval_x only moves on clock edges.
    always_comb begin
        eval_x    = (state == SWEEP) ? idx[N-1:0] : '0;
        busy      = (state == SWEEP) || (state == XFORM);
        done      = (state == DONE);
        state_dbg = state;
    end

    // Sequencer: sweep capture, butterfly stages and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            stage     <= '0;
            truth_tab <= '0;
            anf       <= '0;
            weight    <= '0;
            res_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        truth_tab <= '0;
                        anf       <= '0;
                        weight    <= '0;
                        res_valid <= 1'b0;
                        idx       <= '0;
                        state     <= SWEEP;
                    end
                end
                SWEEP: begin
                    truth_tab[idx[N-1:0]] <= eval_z;
                    weight                <= weight + (N+1)'(eval_z);
                    idx                   <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        // The last bit is still in flight, so take it straight from eval_z.
                        anf   <= {eval_z, truth_tab[TT_W-2:0]};
                        stage <= '0;
                        state <= XFORM;
                    end
                end
                XFORM: begin
                    anf   <= anf_next;
                    stage <= stage + 1'b1;
                    if (stage == LAST_STAGE) begin
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zhegalkin_anf_sweeper.sv
// Directed bench for the ANF sweeper with swappable behavioural evaluators.
module tb_zhegalkin_anf_sweeper;
    import zhegalkin_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  eval_x;
    logic        eval_z;
    logic        busy;
    logic        done;
    logic        res_valid;
    logic [15:0] truth_tab;
    logic [15:0] anf;
    logic [4:0]  weight;
    logic [1:0]  state_dbg;

    int          func_sel;
    logic [15:0] rand_tt;
    int          tests  = 0;
    int          failed = 0;
    logic [36:0] exp_q[$];

    zhegalkin_anf_sweeper #(.N(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .eval_x    (eval_x),
        .eval_z    (eval_z),
        .busy      (busy),
        .done      (done),
        .res_valid (res_valid),
        .truth_tab (truth_tab),
        .anf       (anf),
        .weight    (weight),
        .state_dbg (state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    // Behavioural evaluators selected by func_sel
    always_comb begin
        case (func_sel)
            0: eval_z = 1'b1 ^ eval_x[0] ^ eval_x[2] ^ eval_x[3] ^ (eval_x[0] & eval_x[2])
                        ^ (eval_x[1] & eval_x[2]) ^ (eval_x[2] & eval_x[3])
                        ^ (eval_x[1] & eval_x[2] & eval_x[3]);
            1: eval_z = 1'b1;
            2: eval_z = &eval_x;
            3: eval_z = ^eval_x;
            default: eval_z = rand_tt[eval_x];
        endcase
    end

    // Reference ANF: coefficient m is the XOR of f over all sub-vectors of m.
    function automatic logic [15:0] anf_ref(input logic [15:0] tt);
        logic [15:0] r;
        r = '0;
        for (int m = 0; m < 16; m++)
            for (int i = 0; i < 16; i++)
                if ((i & ~m) == 0) r[m] = r[m] ^ tt[i];
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic check_results();
        logic [36:0] e;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            check("truth_tab", truth_tab, e[36:21]);
            check("anf", anf, e[20:5]);
            check("weight", weight, e[4:0]);
        end
    endtask

    // One run from IDLE; optional eval_x stepping check and ignored start pulses.
    task automatic run_sweep(input int sel, input logic [15:0] tt, input logic [15:0] af,
                             input logic [4:0] w, input bit chk_x, input bit pulses);
        int dones;
        dones    = 0;
        func_sel = sel;
        exp_q.push_back({tt, af, w});
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            start = pulses && (k == 5 || k == 20 || k == 21);
            check("busy", busy, k <= 20);
            check("done", done, k == 21);
            check("res_valid", res_valid, k >= 21);
            if (k == 21) check("state_done", state_dbg, DONE);
            if (chk_x && k <= 16) check("eval_x", eval_x, k - 1);
            if (done) begin
                dones++;
                check_results();
            end
        end
        check("done_count", dones, 1);
    endtask

    initial begin
        int dones;
        logic [15:0] t;
        rst      = 1'b1;
        start    = 1'b0;
        func_sel = 0;
        rand_tt  = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_eval_x", eval_x, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_truth_tab", truth_tab, 0);
        check("rst_anf", anf, 0);
        check("rst_weight", weight, 0);
        check("rst_state", state_dbg, IDLE);
        rst = 1'b0;

        // Polynomial from the datasheet, constants, full AND, parity
        run_sweep(0, 16'h0AC5, 16'h5173, 5'd6, 1'b0, 1'b0);
        run_sweep(1, 16'hFFFF, 16'h0001, 5'd16, 1'b0, 1'b0);
        run_sweep(2, 16'h8000, 16'h8000, 5'd1, 1'b0, 1'b0);
        run_sweep(3, 16'h6996, 16'h0116, 5'd8, 1'b1, 1'b0);

        // Start pulses while busy and in DONE are ignored
        run_sweep(0, 16'h0AC5, 16'h5173, 5'd6, 1'b0, 1'b1);
        repeat (4) begin
            @(negedge clk);
            check("no_requeue_busy", busy, 0);
        end

        // Random function against the reference transform
        for (int r = 0; r < 3; r++) begin
            t       = 16'($urandom_range(0, 65535));
            rand_tt = t;
            run_sweep(4, t, anf_ref(t), 5'($countones(t)), 1'b0, 1'b0);
        end

        // Reset mid-sweep discards partial results
        func_sel = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("mid_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_eval_x", eval_x, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_res_valid", res_valid, 0);
        check("mid_rst_truth_tab", truth_tab, 0);
        check("mid_rst_anf", anf, 0);
        check("mid_rst_weight", weight, 0);
        check("mid_rst_state", state_dbg, IDLE);
        rst = 1'b0;
        run_sweep(0, 16'h0AC5, 16'h5173, 5'd6, 1'b0, 1'b0);

        // start held high: back-to-back runs
        func_sel = 3;
        repeat (3) exp_q.push_back({16'h6996, 16'h0116, 5'd8});
        dones = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 75; k++) begin
            @(negedge clk);
            start = (k < 50);
            if (k == 22) check("b2b_res_valid_idle", res_valid, 1);
            if (k == 23) check("b2b_res_valid_cleared", res_valid, 0);
            if (done) begin
                check("b2b_done_cycle", k, (dones == 0) ? 21 : (dones == 1) ? 43 : 65);
                dones++;
                check_results();
            end
        end
        check("b2b_done_count", dones, 3);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
